// File: rtl/hh_stream_pkg.sv
// hh_stream_pkg
// Shared definitions for the multi-channel hh streaming block.
// Holds the stream FSM state type, the frame header tag, the spike counter
// ceiling and the helper that sizes the channel pointer.
// Optional feature macro used by the top: HH_SPIKE_IRQ_EN.
package hh_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_VB   = 2'd2,
    ST_CNT  = 2'd3
  } stream_state_t;

  localparam logic [3:0] HDR_TAG = 4'hA;
  localparam logic [7:0] CNT_MAX = 8'hFF;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hh_core.sv
// hh_core
// Compact integrate-and-reset neuron occupying the hh core slot: the membrane
// voltage rests at -64, integrates the stimulus current every cycle, and
// snaps back to rest once it reaches the peak of +32.
// Ports:
//   clk    system clock
//   rst_n  synchronous, active-low reset (voltage returns to rest)
//   i_stim 16-bit unsigned stimulus current
//   v      signed membrane voltage, V_WIDTH bits
module hh_core #(
  parameter int V_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [15:0]               i_stim,
  output logic signed [V_WIDTH-1:0] v
);

  localparam logic signed [V_WIDTH-1:0] V_REST = V_WIDTH'(-64);
  localparam logic signed [V_WIDTH-1:0] V_PEAK = V_WIDTH'(32);

  // Membrane update: reset after the peak, otherwise integrate the current.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= V_REST;
    end else if (v >= V_PEAK) begin
      v <= V_REST;
    end else begin
      v <= v + $signed(V_WIDTH'(i_stim));
    end
  end

endmodule

// File: rtl/hh_spike_detect.sv
// hh_spike_detect
// Per-channel upward threshold-crossing detector with a registered spike
// pulse and a saturating, clear-on-read spike counter.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   v         signed membrane voltage of this channel
//   clr       clear the counter (snapshot taken by the streamer this cycle)
//   spike     one-cycle spike pulse, one cycle after the crossing sample
//   cnt       saturating spike count
module hh_spike_detect
  import hh_stream_pkg::*;
#(
  parameter int                        V_WIDTH      = 16,
  parameter int                        CNT_WIDTH    = 8,
  parameter logic signed [V_WIDTH-1:0] SPIKE_THRESH = 16'sh0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [V_WIDTH-1:0] v,
  input  logic                      clr,
  output logic                      spike,
  output logic [CNT_WIDTH-1:0]      cnt
);

  logic signed [V_WIDTH-1:0] v_prev;
  logic                      crossing;

  assign crossing = (v_prev < SPIKE_THRESH) && (v >= SPIKE_THRESH);

  // v_prev resets to the threshold itself so no spike can fire straight
  // out of reset. A crossing coinciding with a clear leaves the count at 1,
  // so that spike lands in the next snapshot instead of vanishing.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_prev <= SPIKE_THRESH;
      spike  <= 1'b0;
      cnt    <= '0;
    end else begin
      v_prev <= v;
      spike  <= crossing;
      if (clr) begin
        cnt <= {{(CNT_WIDTH-1){1'b0}}, crossing};
      end else if (crossing && (cnt != CNT_MAX)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hh_array_stream.sv
// hh_array_stream
// NUM_CH hh cores, each fed by its own stimulus current register written
// through a valid/ready config port. Per-channel spikes are detected and
// counted; frames {header, voltage bytes MSB first, count} are streamed one
// byte at a time with backpressure.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cfg_valid/cfg_ready         config write handshake
//   cfg_ch, cfg_current         target channel and its stimulus current
//   cfg_err                     pulse on an accepted out-of-range write
//   stream_en                   enable frame streaming
//   out_data/out_valid/out_ready  byte stream with backpressure
//   spike                       per-channel one-cycle spike pulses
// Optional (macro HH_SPIKE_IRQ_EN): irq_flags, irq, irq_clr sticky spike
// interrupt flags with per-channel clear.
module hh_array_stream
  import hh_stream_pkg::*;
#(
  parameter int                        NUM_CH       = 4,
  parameter int                        I_WIDTH      = 8,
  parameter int                        V_WIDTH      = 16,
  parameter int                        CNT_WIDTH    = 8,
  parameter logic signed [V_WIDTH-1:0] SPIKE_THRESH = 16'sh0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [3:0]         cfg_ch,
  input  logic [I_WIDTH-1:0] cfg_current,
  output logic               cfg_err,
  input  logic               stream_en,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_CH-1:0]  spike
`ifdef HH_SPIKE_IRQ_EN
  ,
  output logic [NUM_CH-1:0]  irq_flags,
  output logic               irq,
  input  logic [NUM_CH-1:0]  irq_clr
`endif
);

  localparam int CW = ch_idx_width(NUM_CH);
  localparam int NB = V_WIDTH / 8;

  logic [I_WIDTH-1:0]        current_q [NUM_CH];
  logic signed [V_WIDTH-1:0] v_ch      [NUM_CH];
  logic [CNT_WIDTH-1:0]      cnt_ch    [NUM_CH];
  logic [NUM_CH-1:0]         clr_ch;
  logic                      cfg_fire;
  logic                      cfg_in_range;
  stream_state_t             state_q;
  stream_state_t             state_d;
  logic [CW-1:0]             ch_ptr;
  logic [CW-1:0]             ptr_d;
  logic [3:0]                byte_idx;
  logic [V_WIDTH-1:0]        v_sh;
  logic [CNT_WIDTH-1:0]      cnt_snap;
  logic                      fire;
  logic                      hdr_load;
  logic                      last_byte;

  assign cfg_fire     = cfg_valid & cfg_ready;
  assign cfg_in_range = ({1'b0, cfg_ch} < 5'(NUM_CH));
  assign fire         = out_valid & out_ready;

  // Config port: cfg_ready is registered so it reads 0 throughout reset and
  // rises on the first edge after. Out-of-range writes only raise cfg_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) current_q[i] <= '0;
    end else begin
      cfg_ready <= 1'b1;
      cfg_err   <= cfg_fire & ~cfg_in_range;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_fire && cfg_in_range && (cfg_ch == 4'(i))) current_q[i] <= cfg_current;
      end
    end
  end

  // One core and one detector per channel; the streamer clears the counter
  // of whichever channel it is snapshotting.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign clr_ch[g] = hdr_load && (ptr_d == CW'(g));

    hh_core #(.V_WIDTH(V_WIDTH)) u_core (
      .clk    (clk),
      .rst_n  (~rst),
      .i_stim (16'(current_q[g])),
      .v      (v_ch[g])
    );

    hh_spike_detect #(
      .V_WIDTH      (V_WIDTH),
      .CNT_WIDTH    (CNT_WIDTH),
      .SPIKE_THRESH (SPIKE_THRESH)
    ) u_det (
      .clk   (clk),
      .rst   (rst),
      .v     (v_ch[g]),
      .clr   (clr_ch[g]),
      .spike (spike[g]),
      .cnt   (cnt_ch[g])
    );
  end

  // Stream FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state. hdr_load marks every entry into HDR; ptr_d is the channel
  // that frame will carry, so the snapshot and clear target the right one.
  always_comb begin
    state_d   = state_q;
    hdr_load  = 1'b0;
    ptr_d     = ch_ptr;
    last_byte = (byte_idx == 4'(NB - 1));
    unique case (state_q)
      ST_IDLE: begin
        if (stream_en) begin
          state_d  = ST_HDR;
          hdr_load = 1'b1;
        end
      end
      ST_HDR: if (fire) state_d = ST_VB;
      ST_VB:  if (fire && last_byte) state_d = ST_CNT;
      ST_CNT: begin
        if (fire) begin
          ptr_d = (ch_ptr == CW'(NUM_CH - 1)) ? '0 : ch_ptr + 1'b1;
          if (stream_en) begin
            state_d  = ST_HDR;
            hdr_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the state and the frame snapshot only, so each
  // byte holds steady while the sink stalls.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    unique case (state_q)
      ST_HDR: begin
        out_valid = 1'b1;
        out_data  = {HDR_TAG, 4'(ch_ptr)};
      end
      ST_VB: begin
        out_valid = 1'b1;
        out_data  = v_sh[V_WIDTH-1 -: 8];
      end
      ST_CNT: begin
        out_valid = 1'b1;
        out_data  = cnt_snap;
      end
      default: ;
    endcase
  end

  // Frame datapath: the voltage is captured into a shift register that moves
  // up one byte per accepted VB byte, giving MSB-first order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_ptr   <= '0;
      byte_idx <= '0;
      v_sh     <= '0;
      cnt_snap <= '0;
    end else begin
      ch_ptr <= ptr_d;
      if (hdr_load) begin
        v_sh     <= v_ch[ptr_d];
        cnt_snap <= cnt_ch[ptr_d];
        byte_idx <= '0;
      end else if ((state_q == ST_VB) && fire) begin
        v_sh     <= v_sh << 8;
        byte_idx <= last_byte ? 4'd0 : byte_idx + 4'd1;
      end
    end
  end

`ifdef HH_SPIKE_IRQ_EN
  // Sticky flags: a spike in the same cycle as its clear wins.
  always_ff @(posedge clk) begin
    if (rst) irq_flags <= '0;
    else     irq_flags <= (irq_flags & ~irq_clr) | spike;
  end

  assign irq = |irq_flags;
`endif

endmodule

// File: tb/tb_hh_array_stream.sv
// tb_hh_array_stream
// Directed bench for hh_array_stream with the default parameters
// (4 channels, 16-bit voltage). Resting channels stream voltage 0xFFC0.
// Optional feature macro exercised when defined: HH_SPIKE_IRQ_EN.
module tb_hh_array_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_ch;
  logic [7:0] cfg_current;
  logic       cfg_err;
  logic       stream_en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] spike;
`ifdef HH_SPIKE_IRQ_EN
  logic [3:0] irq_flags;
  logic       irq;
  logic [3:0] irq_clr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hh_array_stream dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_current (cfg_current),
    .cfg_err     (cfg_err),
    .stream_en   (stream_en),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .spike       (spike)
`ifdef HH_SPIKE_IRQ_EN
    ,
    .irq_flags   (irq_flags),
    .irq         (irq),
    .irq_clr     (irq_clr)
`endif
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One config write; cfg_ready is already high outside reset.
  task automatic applyStimulus(input logic [3:0] ch, input logic [7:0] cur);
    cfg_ch      = ch;
    cfg_current = cur;
    cfg_valid   = 1'b1;
    @(posedge clk); #1;
    cfg_valid   = 1'b0;
  endtask

  // Waits (bounded) for a valid byte, samples it mid-cycle, and returns just
  // after the edge that consumes it.
  task automatic getByte(output logic [7:0] b, output logic ok);
    int n;
    n  = 0;
    ok = 1'b0;
    b  = '0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (out_valid) begin
      ok = 1'b1;
      b  = out_data;
      @(posedge clk); #1;
    end
  endtask

  task automatic expectByte(input string tag, input logic [7:0] exp);
    logic [7:0] b;
    logic       ok;
    getByte(b, ok);
    if (!ok) checkOutput({tag, " timeout"}, 32'd0, 32'd1);
    else     checkOutput(tag, 32'(b), 32'(exp));
  endtask

  task automatic expectFrame(input int ch, input logic [15:0] v, input logic [7:0] cnt);
    string t;
    t = $sformatf("ch%0d", ch);
    expectByte({t, " hdr"},  {4'hA, 4'(ch)});
    expectByte({t, " v_hi"}, v[15:8]);
    expectByte({t, " v_lo"}, v[7:0]);
    expectByte({t, " cnt"},  cnt);
  endtask

  // Hard stop in case something above stalls beyond its own bounds.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] seen;
    rst         = 1'b1;
    cfg_valid   = 1'b0;
    cfg_ch      = '0;
    cfg_current = '0;
    stream_en   = 1'b0;
    out_ready   = 1'b1;
`ifdef HH_SPIKE_IRQ_EN
    irq_clr     = '0;
`endif

    // Reset and idle.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst cfg_ready", 32'(cfg_ready), 32'd0);
    checkOutput("rst out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle cfg_ready", 32'(cfg_ready), 32'd1);
    checkOutput("idle out_valid", 32'(out_valid), 32'd0);
    checkOutput("idle out_data",  32'(out_data),  32'd0);
    checkOutput("idle spike",     32'(spike),     32'd0);
    checkOutput("idle cfg_err",   32'(cfg_err),   32'd0);
`ifdef HH_SPIKE_IRQ_EN
    checkOutput("idle irq", 32'(irq), 32'd0);
`endif

    // Streaming with ch2 driven at 40: its voltage cycles -64,-24,16,56
    // and its counter reaches 2 by the time its first frame starts.
    applyStimulus(4'd2, 8'd40);
    stream_en = 1'b1;
    expectFrame(0, 16'hFFC0, 8'd0);
    expectFrame(1, 16'hFFC0, 8'd0);
    expectFrame(2, 16'hFFC0, 8'd2);
    expectFrame(3, 16'hFFC0, 8'd0);
    expectFrame(0, 16'hFFC0, 8'd0);
    expectByte("ch1 hdr before reset", 8'hA1);

    // Reset in the middle of a frame.
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midframe rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("midframe rst out_data",  32'(out_data),  32'd0);
    stream_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Spike on ch1: with current 255 the voltage alternates -64/191.
    applyStimulus(4'd1, 8'd255);
    @(posedge clk); #1;
    checkOutput("spike before", 32'(spike), 32'd0);
    @(posedge clk); #1;
    checkOutput("spike pulse", 32'(spike), 32'b0010);
    @(posedge clk); #1;
    checkOutput("spike after", 32'(spike), 32'd0);
    repeat (700) @(posedge clk);
    #1;
    applyStimulus(4'd1, 8'd0);
    repeat (5) @(posedge clk);
    #1;
    stream_en = 1'b1;
    expectFrame(0, 16'hFFC0, 8'd0);
    expectFrame(1, 16'hFFC0, 8'd255);
    expectFrame(2, 16'hFFC0, 8'd0);
    expectFrame(3, 16'hFFC0, 8'd0);
    expectFrame(0, 16'hFFC0, 8'd0);
    expectFrame(1, 16'hFFC0, 8'd0);

    // Backpressure mid-voltage, with a config write landing in the stall.
    expectByte("stall hdr", 8'hA2);
    out_ready = 1'b0;
    applyStimulus(4'd0, 8'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("stall valid %0d", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("stall data %0d", i),  32'(out_data),  32'hFF);
    end
    out_ready = 1'b1;
    expectByte("resume v_hi", 8'hFF);
    expectByte("resume v_lo", 8'hC0);
    expectByte("resume cnt",  8'h00);

    // Dropping stream_en mid-frame still completes the frame.
    expectByte("drop hdr", 8'hA3);
    stream_en = 1'b0;
    expectByte("drop v_hi", 8'hFF);
    expectByte("drop v_lo", 8'hC0);
    expectByte("drop cnt",  8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("after drop valid %0d", i), 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Out-of-range config write: error pulse, no current changes anywhere.
    cfg_ch      = 4'd7;
    cfg_current = 8'd255;
    cfg_valid   = 1'b1;
    @(posedge clk); #1;
    checkOutput("cfg_err pulse", 32'(cfg_err), 32'd1);
    cfg_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("cfg_err clears", 32'(cfg_err), 32'd0);
    seen = '0;
    repeat (10) begin
      @(posedge clk); #1;
      seen = seen | spike;
    end
    checkOutput("no spike after bad write", 32'(seen), 32'd0);

`ifdef HH_SPIKE_IRQ_EN
    // Sticky IRQ: set wins over a simultaneous clear, plain clear drops it.
    applyStimulus(4'd3, 8'd255);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("irq spike3", 32'(spike), 32'b1000);
    irq_clr = 4'b1000;
    @(posedge clk); #1;
    checkOutput("irq flags set", 32'(irq_flags), 32'b1000);
    checkOutput("irq set",       32'(irq),       32'd1);
    @(posedge clk); #1;
    checkOutput("irq cleared", 32'(irq), 32'd0);
    irq_clr = '0;
    applyStimulus(4'd3, 8'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
